// File: rtl/pc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// pc_seq_ctrl - multi-cycle program sequencer for the ONC-16 core.
//
// Owns the program counter and instruction register, runs the instruction
// memory fetch handshake and steps each instruction through
// FETCH -> DECODE -> EXEC (-> BR_EVAL -> BR_RES for conditional branches).
//
// Optional feature macro: SEQ_FAST_JUMP_EN
//   When defined, an unconditional jump is resolved in DECODE: pc loads
//   br_target and the sequencer returns straight to FETCH, skipping EXEC.
//
// Ports:
//   clock          system clock, rising edge
//   rst            asynchronous active-high reset
//   imem_req       fetch request (high for the whole FETCH state)
//   imem_addr      fetch address, always equal to pc
//   imem_ack       fetch complete, imem_data valid this cycle
//   imem_data      fetched instruction
//   ir             instruction register, feeds the decoder
//   dec_is_branch  IR is a conditional branch
//   dec_is_jump    IR is an unconditional jump
//   dec_is_halt    IR is HALT
//   dec_sets_flags IR updates the flags
//   br_target      branch/jump target address
//   stall          execute unit needs another cycle
//   exec_en        execute-unit enable
//   fr_we          flag-register load pulse
//   bre            branch-evaluation enable to the flag decoder
//   is_br          branch-taken result from the flag decoder
//   pc             program counter
//   halted         core halted
// -----------------------------------------------------------------------------
module pc_seq_ctrl #(
  parameter int              PC_W    = 16,
  parameter int              IR_W    = 16,
  parameter logic [PC_W-1:0] RST_VEC = 16'h0000
) (
  input  logic            clock,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [IR_W-1:0] imem_data,
  output logic [IR_W-1:0] ir,
  input  logic            dec_is_branch,
  input  logic            dec_is_jump,
  input  logic            dec_is_halt,
  input  logic            dec_sets_flags,
  input  logic [PC_W-1:0] br_target,
  input  logic            stall,
  output logic            exec_en,
  output logic            fr_we,
  output logic            bre,
  input  logic            is_br,
  output logic [PC_W-1:0] pc,
  output logic            halted
);

  typedef enum logic [2:0] {
    S_RST     = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC    = 3'd3,
    S_BR_EVAL = 3'd4,
    S_BR_RES  = 3'd5,
    S_HALT    = 3'd6
  } state_t;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t          state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [IR_W-1:0] ir_reg, ir_next;

  // State, PC and IR registers.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_reg <= S_RST;
      pc_reg    <= RST_VEC;
      ir_reg    <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    imem_req   = 1'b0;
    exec_en    = 1'b0;
    bre        = 1'b0;
    halted     = 1'b0;

    unique case (state_reg)
      S_RST: begin
        state_next = S_FETCH;
      end

      S_FETCH: begin
        imem_req = 1'b1;
        // Ack may arrive in the same cycle req rises (zero-wait memory).
        if (imem_ack) begin
          ir_next    = imem_data;
          state_next = S_DECODE;
        end
      end

      S_DECODE: begin
        // Halt outranks branch, branch outranks jump.
        if (dec_is_halt) begin
          state_next = S_HALT;
`ifdef SEQ_FAST_JUMP_EN
        end else if (dec_is_jump && !dec_is_branch) begin
          pc_next    = br_target;
          state_next = S_FETCH;
`endif
        end else begin
          state_next = S_EXEC;
        end
      end

      S_EXEC: begin
        exec_en = 1'b1;
        if (!stall) begin
          if (dec_is_branch) begin
            state_next = S_BR_EVAL;
          end else if (dec_is_jump) begin
            pc_next    = br_target;
            state_next = S_FETCH;
          end else begin
            pc_next    = pc_reg + PC_ONE;  // wraps modulo 2^PC_W
            state_next = S_FETCH;
          end
        end
      end

      S_BR_EVAL: begin
        // One-cycle window for the flag decoder to evaluate the condition.
        bre        = 1'b1;
        state_next = S_BR_RES;
      end

      S_BR_RES: begin
        pc_next    = is_br ? br_target : (pc_reg + PC_ONE);
        state_next = S_FETCH;
      end

      S_HALT: begin
        // Terminal until reset.
        halted = 1'b1;
      end

      default: begin
        state_next = S_RST;
      end
    endcase
  end

  // Flags load only on the cycle the execute unit actually completes.
  assign fr_we     = exec_en & ~stall & dec_sets_flags;
  assign pc        = pc_reg;
  assign imem_addr = pc_reg;
  assign ir        = ir_reg;

endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
- Multi-cycle program sequencer for the ONC-16 core.
- Owns the PC and the instruction register (IR); runs the instruction-memory fetch handshake; sequences execute.
- Drives the flag-register load enable and the branch-evaluation enable (bre) of the flag register/decoder; consumes its is_br result to choose the next PC.

Parameters:
- PC_W, 16, PC / instruction-address width (word addressed).
- IR_W, 16, instruction width.
- RST_VEC, 16'h0000, PC value loaded on reset.

Ports:
- clock  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request.
- imem_addr  out  PC_W  fetch address; always equals pc.
- imem_ack  in  1  fetch complete; imem_data valid this cycle.
- imem_data  in  IR_W  fetched instruction.
- ir  out  IR_W  instruction register, feeds the decoder.
- dec_is_branch  in  1  IR is a conditional branch.
- dec_is_jump  in  1  IR is an unconditional jump.
- dec_is_halt  in  1  IR is HALT.
- dec_sets_flags  in  1  IR updates flags.
- br_target  in  PC_W  branch/jump target address.
- stall  in  1  execute unit needs another cycle.
- exec_en  out  1  execute-unit enable.
- fr_we  out  1  flag-register load pulse.
- bre  out  1  branch-evaluation enable to the flag decoder.
- is_br  in  1  branch-taken result from the flag decoder.
- pc  out  PC_W  program counter.
- halted  out  1  core halted.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=S_RST, pc=RST_VEC, ir=0.
  - imem_req, exec_en, fr_we, bre and halted are all 0.
- State outputs are combinational from state: imem_req=(S_FETCH), exec_en=(S_EXEC), bre=(S_BR_EVAL), halted=(S_HALT). fr_we = exec_en & ~stall & dec_sets_flags.
- S_RST: goes unconditionally to S_FETCH on the first clock after rst is released.
- S_FETCH:
  - imem_req held at 1 and imem_addr=pc until imem_ack=1.
  - On ack: ir<=imem_data, go to S_DECODE.
  - An ack in the same cycle that req rises is accepted (zero-wait memory).
  - imem_ack outside S_FETCH is ignored.
- S_DECODE (one cycle; dec_* are valid from here on):
  - dec_is_halt -> S_HALT.
  - Otherwise -> S_EXEC.
- S_EXEC: exec_en=1. While stall=1, stay in S_EXEC; pc and ir hold. On the first cycle with stall=0:
  - dec_is_branch -> S_BR_EVAL.
  - else dec_is_jump -> pc<=br_target, go to S_FETCH.
  - else pc<=pc+1, go to S_FETCH.
- S_BR_EVAL: bre=1 for exactly one cycle, then S_BR_RES.
- S_BR_RES:
  - is_br=1 -> pc<=br_target; is_br=0 -> pc<=pc+1.
  - Then S_FETCH. is_br is ignored in every other state.
- S_HALT: halted=1; pc and ir frozen. The only exit is rst.
- Priority when several decode flags are set: halt > branch > jump.
- pc+1 wraps modulo 2^PC_W (16'hFFFF -> 16'h0000).
- stall is ignored outside S_EXEC.
- Reset mid-operation (any state): outputs drop immediately; the pending fetch is abandoned and no fr_we is issued.
- Latency with zero-wait memory and no stall:
  - ALU/jump instruction: 3 cycles (FETCH, DECODE, EXEC).
  - Conditional branch: 5 cycles.

Optional Feature:
- Macro: SEQ_FAST_JUMP_EN.
- Defined: in S_DECODE, when dec_is_jump=1 and both dec_is_halt=0 and dec_is_branch=0, pc<=br_target and the next state is S_FETCH directly. S_EXEC is skipped (no exec_en, no fr_we), so a jump takes 2 cycles.
- Undefined: jumps go through S_EXEC as described above (3 cycles, stall honoured).

Test Plan:
- Reset, then zero-wait memory returning a flag-setting ALU op at 0x0000:
  - imem_req rises 1 cycle after rst falls, with imem_addr=0x0000.
  - exec_en and fr_we pulse for exactly 1 cycle.
  - pc=0x0001 and the next fetch is at 0x0001.
- imem_ack delayed 3 cycles: imem_req stays high and imem_addr stays constant all 4 cycles; ir loads only on the ack cycle.
- ALU op with stall=1 for 2 cycles:
  - exec_en is high for 3 cycles.
  - fr_we pulses only on the final cycle.
  - pc increments once.
- Conditional branch with br_target=0x0040:
  - is_br=1 -> bre high for 1 cycle, then pc=0x0040.
  - Repeat with is_br=0 -> pc=old+1.
  - Both cases take 5 cycles per instruction.
- pc=0xFFFF executing a non-branch op -> next imem_addr=0x0000. Jump to 0x1234 -> pc=0x1234, taking 3 cycles without SEQ_FAST_JUMP_EN and 2 cycles with it.
- HALT -> halted=1 and imem_req stays 0 for 20 cycles. Separately, assert rst mid-S_EXEC (stall=1) -> all outputs go to 0 and pc=RST_VEC asynchronously, and fetch restarts at RST_VEC.
